// File: rtl/iod_eye_width_trainer.sv
// iod_eye_width_trainer: sweeps the IOD eye-monitor lane width 7..0, locks to the widest clean width
// Ports:
//   FAB_CLK, RESETN (sync, active-low)        clock and reset; FAB_CLK is also the IOD RX_CLK
//   TRAIN_START                               starts a sweep from IDLE, DONE or FAIL
//   EYE_MONITOR_EARLY/LATE                    IOD flags, already in the FAB_CLK domain
//   EYE_MONITOR_LANE_WIDTH/CLEAR_FLAGS        width and flag-clear driven to the IOD
//   RX_SYNC_RST                               IOD receive sync reset during the RST phase
//   TRAIN_BUSY/DONE/FAIL                      sequencer status
//   EYE_PASS_MAP, TRAIN_WIDTH, ERR_CNT        per-width pass map, locked width, post-lock error count
module iod_eye_width_trainer #(
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 256,
  parameter int CNT_W         = 9
) (
  input  logic       FAB_CLK,
  input  logic       RESETN,
  input  logic       TRAIN_START,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  output logic [2:0] EYE_MONITOR_LANE_WIDTH,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic       RX_SYNC_RST,
  output logic       TRAIN_BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_FAIL,
  output logic [7:0] EYE_PASS_MAP,
  output logic [2:0] TRAIN_WIDTH,
  output logic [7:0] ERR_CNT
);
  typedef enum logic [3:0] {IDLE, RST, CLEAR, SETTLE, SAMPLE, NEXT, EVAL, DONE, FAIL} state_t;
  state_t state, state_nxt;
  logic [2:0] w, w_nxt, hi, tw_nxt;
  logic [CNT_W-1:0] cnt;
  logic fail, flag, start_ok;
  assign flag = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
  assign start_ok = TRAIN_START && (state == IDLE || state == DONE || state == FAIL);
  always_comb begin
    hi = 3'd0;
    for (int i = 0; i < 8; i++) if (EYE_PASS_MAP[i]) hi = 3'(i);
  end
  always_comb begin
    state_nxt = state;
    w_nxt = w;
    case (state)
      IDLE, DONE, FAIL: if (start_ok) begin
        state_nxt = RST;
        w_nxt = 3'd7;
      end
      RST:    if (cnt == CNT_W'(RST_CYCLES - 1)) state_nxt = CLEAR;
      CLEAR:  state_nxt = SETTLE;
      SETTLE: if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = SAMPLE;
      SAMPLE: if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) state_nxt = NEXT;
      NEXT: begin
        state_nxt = (w == 3'd0) ? EVAL : CLEAR;
        w_nxt = (w == 3'd0) ? w : w - 3'd1;
      end
      EVAL:    state_nxt = (EYE_PASS_MAP != 8'h00) ? DONE : FAIL;
      default: state_nxt = IDLE;
    endcase
    tw_nxt = (state == EVAL) ? hi : start_ok ? 3'd0 : TRAIN_WIDTH;
  end
  // Status and lane outputs are decoded from the next state so that every output is a flop.
  always_ff @(posedge FAB_CLK) begin
    if (!RESETN) begin
      state <= IDLE;
      w <= 3'd7;
      cnt <= '0;
      fail <= 1'b0;
      EYE_PASS_MAP <= 8'h00;
      TRAIN_WIDTH <= 3'd0;
      ERR_CNT <= 8'h00;
      EYE_MONITOR_LANE_WIDTH <= 3'd0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      RX_SYNC_RST <= 1'b0;
      TRAIN_BUSY <= 1'b0;
      TRAIN_DONE <= 1'b0;
      TRAIN_FAIL <= 1'b0;
    end else begin
      state <= state_nxt;
      w <= w_nxt;
      cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;
      if (state == CLEAR) fail <= 1'b0;
      else if (state == SAMPLE && flag) fail <= 1'b1;
      if (state == DONE && flag && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
      if (state == NEXT) EYE_PASS_MAP[w] <= !fail;
      if (start_ok) begin
        EYE_PASS_MAP <= 8'h00;
        ERR_CNT <= 8'h00;
      end
      TRAIN_WIDTH <= tw_nxt;
      EYE_MONITOR_LANE_WIDTH <= (state_nxt inside {CLEAR, SETTLE, SAMPLE, NEXT}) ? w_nxt :
                                (state_nxt inside {DONE, FAIL}) ? tw_nxt : 3'd0;
      EYE_MONITOR_CLEAR_FLAGS <= state_nxt == CLEAR;
      RX_SYNC_RST <= state_nxt == RST;
      TRAIN_BUSY <= state_nxt inside {RST, CLEAR, SETTLE, SAMPLE, NEXT, EVAL};
      TRAIN_DONE <= state_nxt == DONE;
      TRAIN_FAIL <= state_nxt == FAIL;
    end
  end
endmodule

// File: tb/tb_iod_eye_width_trainer.sv
// tb_iod_eye_width_trainer: randomized scoreboard bench for the eye-width training sequencer
module tb_iod_eye_width_trainer;
  localparam int RC = 8, SC = 16, PC = 256, PW = 2 + SC + PC, TOT = RC + 8 * PW + 1;
  logic clk = 0, rstn = 0, start = 0, early = 0, late = 0;
  logic [2:0] lane, tw;
  logic clr, rx, busy, done, fail;
  logic [7:0] map, err;
  iod_eye_width_trainer dut (
    .FAB_CLK(clk), .RESETN(rstn), .TRAIN_START(start),
    .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late),
    .EYE_MONITOR_LANE_WIDTH(lane), .EYE_MONITOR_CLEAR_FLAGS(clr), .RX_SYNC_RST(rx),
    .TRAIN_BUSY(busy), .TRAIN_DONE(done), .TRAIN_FAIL(fail),
    .EYE_PASS_MAP(map), .TRAIN_WIDTH(tw), .ERR_CNT(err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [7:0] map; logic [2:0] width; logic ok; int at;} res_t;
  res_t res_q[$];
  int clr_q[$];
  int err_q[$];
  int n_cmp = 0, n_bad = 0;
  int hit[8];
  bit full[8], settle[8];
  task automatic chk(input string nm, input longint a, input longint e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  initial begin
    bit p_dn = 0, p_rx = 0;
    int rst_len = 0;
    int last_err = 0;
    res_t r;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        chk("reset_outputs", {lane, clr, rx, busy, done, fail, map, tw, err}, 0);
        p_dn = 0;
        p_rx = 0;
        rst_len = 0;
      end else begin
        if (clr) begin
          if (clr_q.size() == 0) chk("clear_unexpected", 1, 0);
          else chk("clear_lane", lane, clr_q.pop_front());
        end
        if (rx) rst_len++;
        if (rx && !p_rx && err_q.size() > 0) begin
          chk("err_saturated", last_err, err_q.pop_front());
          chk("err_cleared", err, 0);
        end
        if (!rx && p_rx) begin
          chk("rst_len", rst_len, RC);
          rst_len = 0;
        end
        if ((done || fail) && !p_dn) begin
          if (res_q.size() == 0) chk("result_unexpected", 1, 0);
          else begin
            r = res_q.pop_front();
            chk("pass_map", map, r.map);
            chk("train_width", tw, r.width);
            chk("lane_locked", lane, r.width);
            chk("done", done, r.ok);
            chk("fail", fail, !r.ok);
            chk("result_cycle", cyc, r.at);
            chk("err_at_lock", err, 0);
            chk("busy_at_lock", busy, 0);
          end
        end
        if (res_q.size() > 0 && cyc > res_q[0].at + 4) begin
          chk("result_timeout", cyc, res_q[0].at);
          void'(res_q.pop_front());
        end
        p_dn = done || fail;
        p_rx = rx;
        last_err = err;
      end
    end
  end
  task automatic cfg_clean();
    for (int i = 0; i < 8; i++) begin
      hit[i] = -1;
      full[i] = 0;
      settle[i] = 0;
    end
  endtask
  task automatic cfg_random();
    for (int i = 0; i < 8; i++) begin
      int m = $urandom_range(0, 3);
      hit[i] = (m == 1) ? $urandom_range(0, PC - 1) : -1;
      full[i] = m == 3;
      settle[i] = m == 2;
    end
  endtask
  task automatic run(input int sp_t, input int ab_t);
    logic [7:0] m;
    res_t r;
    int hw;
    m = 0;
    hw = 0;
    @(negedge clk);
    start = 1;
    for (int i = 0; i < 8; i++) m[i] = !(full[i] || hit[i] >= 0);
    for (int i = 0; i < 8; i++) if (m[i]) hw = i;
    for (int i = 7; i >= 0; i--) clr_q.push_back(i);
    r.map = m;
    r.width = 3'(hw);
    r.ok = m != 0;
    r.at = cyc + 1 + TOT;
    if (ab_t < 0) res_q.push_back(r);
    for (int t = 0; t < TOT; t++) begin
      bit f;
      int sel;
      @(negedge clk);
      start = t == sp_t;
      f = 0;
      if (t >= RC && (t - RC) / PW < 8) begin
        int o = (t - RC) % PW;
        int w = 7 - (t - RC) / PW;
        if (o >= 1 && o <= SC) f = settle[w];
        else if (o > SC && o <= SC + PC) f = full[w] || hit[w] == o - SC - 1;
      end
      sel = $urandom_range(0, 2);
      early = f && sel != 1;
      late = f && sel != 0;
      if (t == ab_t) begin
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        start = 0;
        clr_q.delete();
        break;
      end
    end
    @(negedge clk);
    early = 0;
    late = 0;
    start = 0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rstn = 1;
    cfg_clean();
    run(-1, -1);
    early = 1;
    repeat (300) @(negedge clk);
    early = 0;
    err_q.push_back(255);
    cfg_clean();
    for (int i = 5; i < 8; i++) full[i] = 1;
    run(-1, -1);
    cfg_clean();
    for (int i = 0; i < 8; i++) hit[i] = $urandom_range(0, PC - 1);
    run(-1, -1);
    cfg_clean();
    settle[7] = 1;
    run(-1, -1);
    cfg_clean();
    hit[6] = PC - 1;
    run(-1, -1);
    cfg_clean();
    run(RC + PW + 50, RC + 4 * PW + 100);
    run(-1, -1);
    for (int k = 0; k < 3; k++) begin
      cfg_random();
      run(RC + $urandom_range(0, 7) * PW + SC + 1 + $urandom_range(0, PC - 1), -1);
    end
    repeat (4) @(negedge clk);
    chk("results_drained", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/iod_eye_width_trainer.md
Name: iod_eye_width_trainer

Overview:
- Training sequencer for one clock-training IOD lane that has its eye monitor enabled and dynamic lane width.
- Resets the lane, sweeps EYE_MONITOR_LANE_WIDTH from 7 down to 0, clears the flags, waits, then samples EARLY/LATE for each width.
- Locks to the largest width that produced no flags. Reports a pass map, the locked width and a post-lock error count.
- Sits in the FAB_CLK domain between the IOD wrapper and the fabric bring-up / reset controller.

Parameters:
- RST_CYCLES, 8, cycles RX_SYNC_RST is held at training start (>=1).
- SETTLE_CYCLES, 16, cycles after a flag clear during which EARLY/LATE are ignored (>=1).
- SAMPLE_CYCLES, 256, cycles during which EARLY/LATE are accumulated per width (>=1).
- CNT_W, 9, phase counter width. Must hold max(RST_CYCLES, SETTLE_CYCLES, SAMPLE_CYCLES).

Ports:
- FAB_CLK  in  1  fabric clock; also the IOD RX_CLK.
- RESETN  in  1  synchronous active-low reset.
- TRAIN_START  in  1  single-cycle request; honoured only in IDLE, DONE or FAIL.
- EYE_MONITOR_EARLY  in  1  IOD early flag, synchronous to FAB_CLK.
- EYE_MONITOR_LATE  in  1  IOD late flag, synchronous to FAB_CLK.
- EYE_MONITOR_LANE_WIDTH  out  3  width driven to the IOD.
- EYE_MONITOR_CLEAR_FLAGS  out  1  flag-clear pulse to the IOD.
- RX_SYNC_RST  out  1  IOD receive sync reset.
- TRAIN_BUSY  out  1  high in RST, CLEAR, SETTLE, SAMPLE, NEXT and EVAL.
- TRAIN_DONE  out  1  high in DONE (locked).
- TRAIN_FAIL  out  1  high in FAIL (no clean width).
- EYE_PASS_MAP  out  8  bit w = 1 if width w sampled clean.
- TRAIN_WIDTH  out  3  locked width; 0 in FAIL.
- ERR_CNT  out  8  saturating count of flagged cycles while in DONE.

Behaviour:
- Reset (RESETN=0 at a FAB_CLK edge, in any state including mid-sweep) forces state IDLE and all outputs to 0: LANE_WIDTH=0, CLEAR_FLAGS=0, RX_SYNC_RST=0, MAP=0x00, TRAIN_WIDTH=0, ERR_CNT=0. Internal w register=7, fail flag=0, counter=0.
- IDLE: TRAIN_START=1 -> RST. MAP, ERR_CNT and TRAIN_WIDTH are cleared and w=7 on that edge.
- RST: RX_SYNC_RST=1 for exactly RST_CYCLES cycles -> CLEAR.
- CLEAR: exactly 1 cycle.
  - CLEAR_FLAGS=1 and LANE_WIDTH=w.
  - The internal fail flag is cleared.
  - Next state SETTLE.
- SETTLE: SETTLE_CYCLES cycles. LANE_WIDTH=w, flags ignored -> SAMPLE.
- SAMPLE: SAMPLE_CYCLES cycles. If EARLY|LATE is high in any of these cycles, the fail flag is set -> NEXT.
- NEXT: 1 cycle. MAP[w] <= !fail.
  - If w==0 -> EVAL.
  - Otherwise w <= w-1 -> CLEAR.
- EVAL: 1 cycle. Selects the highest set bit of MAP.
  - If one exists: TRAIN_WIDTH and LANE_WIDTH take that index -> DONE.
  - If MAP==0: TRAIN_WIDTH=0, LANE_WIDTH=0 -> FAIL.
- Per-width time is 2+SETTLE_CYCLES+SAMPLE_CYCLES cycles.
- Total time from the TRAIN_START edge to TRAIN_DONE/TRAIN_FAIL first high is RST_CYCLES + 8*(2+SETTLE_CYCLES+SAMPLE_CYCLES) + 1 cycles. With default parameters this is 2201 cycles.
- The sweep always visits all 8 widths; there is no early exit.
- DONE:
  - LANE_WIDTH is held at TRAIN_WIDTH.
  - Each cycle with EARLY|LATE high increments ERR_CNT, saturating at 255.
  - CLEAR_FLAGS stays 0.
- FAIL: holds its outputs.
- TRAIN_START in DONE or FAIL restarts exactly as from IDLE.
- TRAIN_START in any busy state is ignored; it is neither queued nor restarts the sweep.
- TRAIN_START and RESETN=0 in the same cycle: reset wins.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Flags are sampled in the cycle they are presented; there is no synchronizer, because both flags share FAB_CLK with the IOD.

Test Plan:
- Flags held 0 throughout, defaults, TRAIN_START at cycle 0 -> RX_SYNC_RST high exactly 8 cycles; 8 CLEAR_FLAGS pulses with LANE_WIDTH 7,6..0; TRAIN_DONE high at cycle 2201; MAP=0xFF; TRAIN_WIDTH=7.
- LATE=1 during SAMPLE whenever LANE_WIDTH>=5 -> MAP=0x1F, TRAIN_WIDTH=4, LANE_WIDTH=4 in DONE.
- EARLY pulsed 1 cycle in every SAMPLE phase -> MAP=0x00, TRAIN_FAIL=1, TRAIN_WIDTH=0, TRAIN_DONE=0.
- Flag high only during SETTLE of width 7 -> ignored; MAP=0xFF.
- Flag high on the last SAMPLE cycle of width 6 -> MAP=0xBF; TRAIN_WIDTH=7.
- Two checks in one run:
  - TRAIN_START mid-SAMPLE -> no effect on the sequence.
  - RESETN=0 for 1 cycle mid-sweep -> IDLE with all outputs 0 next cycle; a subsequent TRAIN_START runs a full clean sweep.
- In DONE, EARLY held 300 cycles -> ERR_CNT=255, not wrapped. TRAIN_START then clears ERR_CNT to 0 and re-asserts RX_SYNC_RST.
